// File: rtl/cpu_block_transfer_controller.sv
// CPU-side controller for the snoopy invalidate cache: serves hits, runs
// victim writeback + refill on misses, and issues upgrade invalidates.
//   state     | meaning
//   IDLE      | waiting for a CPU request; evaluates hit/miss
//   SERVE     | one-cycle hit access (read or write)
//   DONE      | holds completion until the CPU strobes drop
//   WB_GRANT  | requesting the bus for a victim writeback word
//   WB_XFER   | writeback word on the bus
//   RD_GRANT  | requesting the bus for a refill word
//   RD_XFER   | refill word on the bus
//   RD_COMMIT | write tag/state once the block is in (and invalidated if exclusive)
//   INV_WAIT  | upgrade: waiting for all snoopers to invalidate
module cpu_block_transfer_controller #(
  parameter int OFFSET_WIDTH = 2,
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int STATE_WIDTH = 2,
  parameter logic [STATE_WIDTH-1:0] INVALID_STATE = '0,
  parameter bit BURST_MODE = 1'b0,
  localparam int ADDRESS_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic                     cpu_read_enabled,
  input  logic                     cpu_write_enabled,
  input  logic [DATA_WIDTH-1:0]    cpu_data_out,
  output logic [DATA_WIDTH-1:0]    cpu_data_in,
  output logic                     cpu_function_complete,
  input  logic                     cache_hit,
  input  logic [TAG_WIDTH-1:0]     cache_tag_out,
  input  logic [DATA_WIDTH-1:0]    cache_data_out,
  output logic [OFFSET_WIDTH-1:0]  cache_offset,
  output logic [DATA_WIDTH-1:0]    cache_data_in,
  output logic [STATE_WIDTH-1:0]   cache_state_in,
  output logic                     cache_write_data,
  output logic                     cache_write_tag,
  output logic                     cache_write_state,
  input  logic                     write_back_required,
  input  logic                     read_exclusive_required,
  input  logic                     invalidate_required,
  input  logic [STATE_WIDTH-1:0]   protocol_state_in,
  output logic                     bus_request,
  input  logic                     bus_grant,
  output logic [2:0]               bus_command,
  output logic [ADDRESS_WIDTH-1:0] bus_address,
  output logic [DATA_WIDTH-1:0]    bus_data_out,
  input  logic [DATA_WIDTH-1:0]    bus_data_in,
  output logic                     bus_read_enabled,
  output logic                     bus_write_enabled,
  input  logic                     bus_function_complete,
  input  logic                     bus_invalidated,
  output logic                     access_enable
);

  typedef enum logic [3:0] {
    IDLE, SERVE, DONE, WB_GRANT, WB_XFER, RD_GRANT, RD_XFER, RD_COMMIT, INV_WAIT
  } state_t;

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_READ = 3'd1;
  localparam logic [2:0] CMD_READ_EXCLUSIVE = 3'd2;
  localparam logic [2:0] CMD_INVALIDATE = 3'd3;
  localparam logic [2:0] CMD_WRITEBACK = 3'd4;
  localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

  state_t state, state_next;
  logic [OFFSET_WIDTH-1:0] word_counter, word_counter_next;
  logic [TAG_WIDTH-1:0] victim_tag, victim_tag_next;
  logic exclusive_flag, exclusive_flag_next;
  // one idle cycle in a grant state forces the arbiter to see request drop
  logic rearb_gap, rearb_gap_next;
  logic owned, owned_next;
  logic inv_seen, inv_seen_next;

  logic cpu_request;
  logic last_word;
  logic in_wb;
  logic [TAG_WIDTH-1:0] cpu_tag;
  logic [INDEX_WIDTH-1:0] cpu_index;
  logic [OFFSET_WIDTH-1:0] cpu_offset;
  logic [2:0] read_command;

  assign cpu_request = cpu_read_enabled | cpu_write_enabled;
  assign last_word = (word_counter == LAST_WORD);
  assign in_wb = (state == WB_GRANT) || (state == WB_XFER);
  assign cpu_tag = cpu_address[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign cpu_index = cpu_address[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cpu_offset = cpu_address[OFFSET_WIDTH-1:0];
  assign read_command = exclusive_flag ? CMD_READ_EXCLUSIVE : CMD_READ;

  assign cpu_data_in = cache_data_out;
  assign bus_request = (bus_command != CMD_NONE) || (BURST_MODE && owned);
  assign bus_address = (bus_command != CMD_NONE)
                     ? {(in_wb ? victim_tag : cpu_tag), cpu_index, word_counter}
                     : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      word_counter <= '0;
      victim_tag <= '0;
      exclusive_flag <= 1'b0;
      rearb_gap <= 1'b0;
      owned <= 1'b0;
      inv_seen <= 1'b0;
    end else begin
      state <= state_next;
      word_counter <= word_counter_next;
      victim_tag <= victim_tag_next;
      exclusive_flag <= exclusive_flag_next;
      rearb_gap <= rearb_gap_next;
      owned <= owned_next;
      inv_seen <= inv_seen_next;
    end
  end

  always_comb begin
    state_next = state;
    word_counter_next = word_counter;
    victim_tag_next = victim_tag;
    exclusive_flag_next = exclusive_flag;
    rearb_gap_next = 1'b0;
    owned_next = owned;
    inv_seen_next = inv_seen;
    cpu_function_complete = 1'b0;
    access_enable = 1'b0;
    cache_offset = word_counter;
    cache_data_in = '0;
    cache_state_in = '0;
    cache_write_data = 1'b0;
    cache_write_tag = 1'b0;
    cache_write_state = 1'b0;
    bus_command = CMD_NONE;
    bus_data_out = '0;
    bus_read_enabled = 1'b0;
    bus_write_enabled = 1'b0;

    case (state)
      IDLE: begin
        cache_offset = cpu_offset;
        owned_next = 1'b0;
        inv_seen_next = 1'b0;
        if (cpu_request) begin
          if (cache_hit) begin
            state_next = invalidate_required ? INV_WAIT : SERVE;
          end else begin
            exclusive_flag_next = read_exclusive_required;
            if (write_back_required) begin
              victim_tag_next = cache_tag_out;
              state_next = WB_GRANT;
            end else begin
              state_next = RD_GRANT;
            end
          end
        end
      end
      SERVE: begin
        cache_offset = cpu_offset;
        cpu_function_complete = 1'b1;
        access_enable = 1'b1;
        cache_write_data = cpu_write_enabled;
        cache_write_state = cpu_write_enabled;
        cache_data_in = cpu_data_out;
        cache_state_in = protocol_state_in;
        state_next = DONE;
      end
      DONE: begin
        cpu_function_complete = 1'b1;
        if (!cpu_request) state_next = IDLE;
      end
      WB_GRANT: begin
        bus_data_out = cache_data_out;
        if (!rearb_gap) begin
          bus_command = CMD_WRITEBACK;
          if (bus_grant || (BURST_MODE && owned)) begin
            owned_next = BURST_MODE;
            state_next = WB_XFER;
          end
        end
      end
      WB_XFER: begin
        bus_command = CMD_WRITEBACK;
        bus_write_enabled = 1'b1;
        bus_data_out = cache_data_out;
        if (bus_function_complete) begin
          word_counter_next = word_counter + 1'b1;
          rearb_gap_next = !BURST_MODE;
          if (last_word) begin
            cache_write_state = 1'b1;
            cache_state_in = INVALID_STATE;
            state_next = RD_GRANT;
          end else begin
            state_next = WB_GRANT;
          end
        end
      end
      RD_GRANT: begin
        if (bus_invalidated) inv_seen_next = 1'b1;
        if (!rearb_gap) begin
          bus_command = read_command;
          if (bus_grant || (BURST_MODE && owned)) begin
            owned_next = BURST_MODE;
            state_next = RD_XFER;
          end
        end
      end
      RD_XFER: begin
        bus_command = read_command;
        bus_read_enabled = 1'b1;
        if (bus_invalidated) inv_seen_next = 1'b1;
        if (bus_function_complete) begin
          cache_write_data = 1'b1;
          cache_data_in = bus_data_in;
          if (last_word) begin
            state_next = RD_COMMIT;
          end else begin
            word_counter_next = word_counter + 1'b1;
            rearb_gap_next = !BURST_MODE;
            state_next = RD_GRANT;
          end
        end
      end
      RD_COMMIT: begin
        if (!exclusive_flag || inv_seen || bus_invalidated) begin
          cache_write_tag = 1'b1;
          cache_write_state = 1'b1;
          cache_state_in = protocol_state_in;
          word_counter_next = '0;
          owned_next = 1'b0;
          inv_seen_next = 1'b0;
          state_next = IDLE;
        end
      end
      INV_WAIT: begin
        bus_command = CMD_INVALIDATE;
        if (bus_grant && bus_invalidated) begin
          cache_write_state = 1'b1;
          cache_state_in = protocol_state_in;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_block_transfer_controller.sv
// Directed bench for cpu_block_transfer_controller: hits, clean/dirty misses,
// exclusive refill, upgrade invalidate, and burst refill aborted by reset.
module tb_cpu_block_transfer_controller;

  localparam logic [3:0] IDX = 4'h5;

  logic clock = 1'b0;
  logic reset, reset_burst;
  logic [13:0] cpu_address;
  logic cpu_read_enabled, cpu_write_enabled;
  logic [15:0] cpu_data_out;
  logic cache_hit;
  logic [7:0] cache_tag_out;
  logic [15:0] cache_data_out;
  logic write_back_required, read_exclusive_required, invalidate_required;
  logic [1:0] protocol_state_in;
  logic bus_grant;
  logic [15:0] bus_data_in;
  logic bus_function_complete, bus_invalidated;

  logic [15:0] cpu_data_in, cache_data_in, bus_data_out;
  logic cpu_function_complete, cache_write_data, cache_write_tag, cache_write_state;
  logic [1:0] cache_offset, cache_state_in;
  logic bus_request, bus_read_enabled, bus_write_enabled, access_enable;
  logic [2:0] bus_command;
  logic [13:0] bus_address;

  logic [15:0] b_cpu_data_in, b_cache_data_in, b_bus_data_out;
  logic b_cpu_function_complete, b_cache_write_data, b_cache_write_tag, b_cache_write_state;
  logic [1:0] b_cache_offset, b_cache_state_in;
  logic b_bus_request, b_bus_read_enabled, b_bus_write_enabled, b_access_enable;
  logic [2:0] b_bus_command;
  logic [13:0] b_bus_address;

  int tests_run = 0;
  int failures = 0;

  always #5 clock = ~clock;

  cpu_block_transfer_controller u_dut (
    .clock(clock), .reset(reset),
    .cpu_address(cpu_address), .cpu_read_enabled(cpu_read_enabled),
    .cpu_write_enabled(cpu_write_enabled), .cpu_data_out(cpu_data_out),
    .cpu_data_in(cpu_data_in), .cpu_function_complete(cpu_function_complete),
    .cache_hit(cache_hit), .cache_tag_out(cache_tag_out), .cache_data_out(cache_data_out),
    .cache_offset(cache_offset), .cache_data_in(cache_data_in), .cache_state_in(cache_state_in),
    .cache_write_data(cache_write_data), .cache_write_tag(cache_write_tag),
    .cache_write_state(cache_write_state),
    .write_back_required(write_back_required), .read_exclusive_required(read_exclusive_required),
    .invalidate_required(invalidate_required), .protocol_state_in(protocol_state_in),
    .bus_request(bus_request), .bus_grant(bus_grant), .bus_command(bus_command),
    .bus_address(bus_address), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
    .bus_read_enabled(bus_read_enabled), .bus_write_enabled(bus_write_enabled),
    .bus_function_complete(bus_function_complete), .bus_invalidated(bus_invalidated),
    .access_enable(access_enable)
  );

  cpu_block_transfer_controller #(.BURST_MODE(1'b1)) u_dut_burst (
    .clock(clock), .reset(reset_burst),
    .cpu_address(cpu_address), .cpu_read_enabled(cpu_read_enabled),
    .cpu_write_enabled(cpu_write_enabled), .cpu_data_out(cpu_data_out),
    .cpu_data_in(b_cpu_data_in), .cpu_function_complete(b_cpu_function_complete),
    .cache_hit(cache_hit), .cache_tag_out(cache_tag_out), .cache_data_out(cache_data_out),
    .cache_offset(b_cache_offset), .cache_data_in(b_cache_data_in),
    .cache_state_in(b_cache_state_in),
    .cache_write_data(b_cache_write_data), .cache_write_tag(b_cache_write_tag),
    .cache_write_state(b_cache_write_state),
    .write_back_required(write_back_required), .read_exclusive_required(read_exclusive_required),
    .invalidate_required(invalidate_required), .protocol_state_in(protocol_state_in),
    .bus_request(b_bus_request), .bus_grant(bus_grant), .bus_command(b_bus_command),
    .bus_address(b_bus_address), .bus_data_out(b_bus_data_out), .bus_data_in(bus_data_in),
    .bus_read_enabled(b_bus_read_enabled), .bus_write_enabled(b_bus_write_enabled),
    .bus_function_complete(bus_function_complete), .bus_invalidated(bus_invalidated),
    .access_enable(b_access_enable)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic wait_bus(input logic [2:0] cmd);
    int n = 0;
    while (!(bus_request && bus_command == cmd) && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    check("bus_req_cmd", {bus_request, bus_command}, {1'b1, cmd});
  endtask

  task automatic wait_complete();
    int n = 0;
    while (!cpu_function_complete && n < 20) begin
      @(negedge clock); #1;
      n++;
    end
    check("cpu_done", cpu_function_complete, 1);
  endtask

  task automatic read_word(input logic [7:0] tag, input logic [1:0] w, input logic [2:0] cmd,
                           input bit last);
    wait_bus(cmd);
    check("rd_addr", bus_address, {tag, IDX, w});
    bus_grant = 1'b1;
    @(negedge clock);
    bus_grant = 1'b0;
    bus_data_in = 16'hA000 + 16'(w);
    bus_function_complete = 1'b1;
    #1;
    check("rd_en", bus_read_enabled, 1);
    check("rd_fill_we", cache_write_data, 1);
    check("rd_fill_data", cache_data_in, 16'hA000 + 16'(w));
    check("rd_fill_off", cache_offset, w);
    @(negedge clock);
    bus_function_complete = 1'b0;
    #1;
    if (!last) check("rd_gap", bus_request, 0);
  endtask

  task automatic write_word(input logic [1:0] w, input bit last);
    cache_data_out = 16'hD000 + 16'(w);
    #1;
    wait_bus(3'd4);
    check("wb_addr", bus_address, {8'h5A, IDX, w});
    bus_grant = 1'b1;
    @(negedge clock);
    bus_grant = 1'b0;
    bus_function_complete = 1'b1;
    #1;
    check("wb_en", bus_write_enabled, 1);
    check("wb_data", bus_data_out, 16'hD000 + 16'(w));
    check("wb_off", cache_offset, w);
    check("wb_state_we", cache_write_state, last);
    if (last) check("wb_inval_state", cache_state_in, 0);
    @(negedge clock);
    bus_function_complete = 1'b0;
    #1;
    if (!last) check("wb_gap", bus_request, 0);
  endtask

  task automatic commit_and_serve(input logic [1:0] state_code);
    check("commit_tag_we", cache_write_tag, 1);
    check("commit_state_we", cache_write_state, 1);
    check("commit_state", cache_state_in, state_code);
    cache_hit = 1'b1;
    wait_complete();
    check("serve_access", access_enable, 1);
    check("serve_offset", cache_offset, cpu_address[1:0]);
    @(negedge clock);
    cpu_read_enabled = 1'b0;
    cpu_write_enabled = 1'b0;
    cache_hit = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("back_idle", cpu_function_complete, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_burst = 1'b1;
    cpu_address = '0; cpu_read_enabled = 1'b0; cpu_write_enabled = 1'b0; cpu_data_out = '0;
    cache_hit = 1'b0; cache_tag_out = '0; cache_data_out = '0;
    write_back_required = 1'b0; read_exclusive_required = 1'b0; invalidate_required = 1'b0;
    protocol_state_in = '0; bus_grant = 1'b0; bus_data_in = '0;
    bus_function_complete = 1'b0; bus_invalidated = 1'b0;

    // reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_req", bus_request, 0);
    check("rst_cmd", bus_command, 0);
    check("rst_addr", bus_address, 0);
    check("rst_done", cpu_function_complete, 0);
    check("rst_we", {cache_write_data, cache_write_tag, cache_write_state}, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("idle_strobes", {bus_read_enabled, bus_write_enabled, access_enable}, 0);

    // read hit at offset 2
    @(negedge clock);
    cpu_address = {8'h3C, IDX, 2'd2};
    cpu_read_enabled = 1'b1; cache_hit = 1'b1; cache_data_out = 16'h1234;
    #1;
    check("hit_offset", cache_offset, 2);
    check("hit_early", cpu_function_complete, 0);
    @(negedge clock); #1;
    check("hit_done", cpu_function_complete, 1);
    check("hit_data", cpu_data_in, 16'h1234);
    check("hit_no_bus", bus_request, 0);
    check("hit_access", access_enable, 1);
    check("hit_no_write", cache_write_data, 0);
    @(negedge clock);
    cpu_read_enabled = 1'b0;
    #1;
    check("done_hold", cpu_function_complete, 1);
    check("done_access", access_enable, 0);
    @(negedge clock); #1;
    check("done_clear", cpu_function_complete, 0);
    cache_hit = 1'b0;

    // clean read miss
    @(negedge clock);
    cpu_address = {8'h3C, IDX, 2'd1};
    cpu_read_enabled = 1'b1; protocol_state_in = 2'd1;
    #1;
    for (int w = 0; w < 4; w++) read_word(8'h3C, 2'(w), 3'd1, w == 3);
    commit_and_serve(2'd1);

    // dirty miss: victim 0x5A written back, then refill of 0x3C
    @(negedge clock);
    cpu_address = {8'h3C, IDX, 2'd3};
    cpu_read_enabled = 1'b1; write_back_required = 1'b1; cache_tag_out = 8'h5A;
    protocol_state_in = 2'd1;
    #1;
    for (int w = 0; w < 4; w++) write_word(2'(w), w == 3);
    write_back_required = 1'b0;
    for (int w = 0; w < 4; w++) read_word(8'h3C, 2'(w), 3'd1, w == 3);
    commit_and_serve(2'd1);

    // write miss needing exclusive ownership; invalidate acknowledged late
    @(negedge clock);
    cpu_address = {8'h77, IDX, 2'd0};
    cpu_write_enabled = 1'b1; cpu_data_out = 16'h5555;
    read_exclusive_required = 1'b1; protocol_state_in = 2'd3;
    #1;
    for (int w = 0; w < 4; w++) read_word(8'h77, 2'(w), 3'd2, w == 3);
    check("excl_wait0", cache_write_tag, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      check("excl_wait", cache_write_tag, 0);
    end
    @(negedge clock);
    bus_invalidated = 1'b1;
    read_exclusive_required = 1'b0;
    #1;
    check("excl_tag_we", cache_write_tag, 1);
    check("excl_state", cache_state_in, 3);
    cache_hit = 1'b1;
    @(negedge clock);
    bus_invalidated = 1'b0;
    #1;
    wait_complete();
    check("excl_data_we", cache_write_data, 1);
    check("excl_data", cache_data_in, 16'h5555);
    @(negedge clock);
    cpu_write_enabled = 1'b0; cache_hit = 1'b0;
    repeat (2) @(negedge clock);

    // write hit on a shared block: upgrade, grant on third cycle
    cpu_address = {8'h3C, IDX, 2'd2};
    cpu_write_enabled = 1'b1; cpu_data_out = 16'hBEEF; cache_hit = 1'b1;
    invalidate_required = 1'b1; protocol_state_in = 2'd3;
    @(negedge clock); #1;
    check("inv_cmd", {bus_request, bus_command}, {1'b1, 3'd3});
    check("inv_no_state", cache_write_state, 0);
    @(negedge clock); #1;
    check("inv_cmd2", bus_command, 3);
    @(negedge clock);
    bus_grant = 1'b1; bus_invalidated = 1'b1;
    #1;
    check("inv_state_we", cache_write_state, 1);
    check("inv_state", cache_state_in, 3);
    @(negedge clock);
    bus_grant = 1'b0; bus_invalidated = 1'b0; invalidate_required = 1'b0;
    #1;
    check("inv_once", cache_write_state, 0);
    check("inv_released", bus_request, 0);
    @(negedge clock); #1;
    check("upg_done", cpu_function_complete, 1);
    check("upg_data_we", cache_write_data, 1);
    check("upg_data", cache_data_in, 16'hBEEF);
    @(negedge clock);
    cpu_write_enabled = 1'b0; cache_hit = 1'b0;
    repeat (2) @(negedge clock);

    // burst refill interrupted by reset on word 2
    reset = 1'b1;
    cpu_address = {8'h3C, IDX, 2'd0};
    cache_data_out = 16'h0000;
    reset_burst = 1'b0;
    cpu_read_enabled = 1'b1; bus_grant = 1'b1;
    @(negedge clock); #1;
    check("b_first", {b_bus_request, b_bus_command}, {1'b1, 3'd1});
    check("b_addr0", b_bus_address, {8'h3C, IDX, 2'd0});
    for (int w = 0; w < 2; w++) begin
      @(negedge clock);
      bus_function_complete = 1'b1; bus_data_in = 16'hC000 + 16'(w);
      #1;
      check("b_rd_en", b_bus_read_enabled, 1);
      check("b_fill_we", b_cache_write_data, 1);
      @(negedge clock);
      bus_function_complete = 1'b0;
      #1;
      check("b_req_held", b_bus_request, 1);
    end
    @(negedge clock); #1;
    check("b_word2", b_bus_address, {8'h3C, IDX, 2'd2});
    check("b_word2_en", b_bus_read_enabled, 1);
    reset_burst = 1'b1;
    #1;
    check("b_rst_bus", {b_bus_request, b_bus_command, b_bus_read_enabled, b_bus_write_enabled}, 0);
    check("b_rst_cache", {b_cache_write_data, b_cache_write_tag, b_cache_write_state}, 0);
    check("b_rst_cpu", {b_cpu_function_complete, b_access_enable}, 0);
    check("b_rst_data", {b_bus_address, b_bus_data_out, b_cache_data_in, b_cache_state_in}, 0);
    check("b_rst_mux", {b_cpu_data_in, b_cache_offset}, 0);
    @(negedge clock);
    reset_burst = 1'b0; bus_grant = 1'b0;
    #1;
    check("b_idle_tag", b_cache_write_tag, 0);
    @(negedge clock); #1;
    check("b_restart_addr", b_bus_address, {8'h3C, IDX, 2'd0});
    check("b_restart_cmd", b_bus_command, 1);
    cpu_read_enabled = 1'b0;
    reset_burst = 1'b1;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
